// File: rtl/cg_pkg.sv
// Shared types for the clock-gating controller: per-channel FSM states and channel limit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cg_pkg;
    localparam int CG_MAX_NCH = 32;

    typedef enum logic [1:0] {
        CG_RUN,
        CG_GATED,
        CG_WAKE
    } cg_state_e;
endpackage

// File: rtl/cg_cell.sv
// Glitch-free gating cell: clk-low-transparent enable latch followed by an AND with clk.
// Latency: enable captured during the low phase takes effect on the next rising edge.
// Backpressure: none.
module cg_cell (
    input  logic clk,
    input  logic en,
    output logic gclk
);
    logic lat;

    // Opaque while clk is high, so en changing at posedge cannot cut a pulse short.
    always_latch begin
        if (!clk) begin
            lat <= en;
        end
    end

    assign gclk = clk & lat;
endmodule

// File: rtl/clk_gate_ctrl.sv
// Multi-channel clock-gating controller: gates a channel after IDLE_CYC idle cycles, wakes on act/force_on.
// Latency: wake sampled at edge k gives the first gclk rise and ready=1 at edge k+1. Optional CGC_SCAN_BYPASS_EN adds test_en.
// Backpressure: none; ready reports when a channel's gated clock is running steadily.
module clk_gate_ctrl
    import cg_pkg::*;
#(
    parameter int NCH      = 8,
    parameter int IDLE_CYC = 4
) (
    input  logic           clk,
    input  logic           rst,
`ifdef CGC_SCAN_BYPASS_EN
    input  logic           test_en,
`endif
    input  logic [NCH-1:0] act,
    input  logic [NCH-1:0] force_on,
    output logic [NCH-1:0] gclk,
    output logic [NCH-1:0] en_q,
    output logic [NCH-1:0] ready,
    output logic [NCH-1:0] gated
);
    localparam int CNT_W = $clog2(IDLE_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IDLE_CYC - 1);

    if (IDLE_CYC < 1) begin : g_bad_idle
        $error("clk_gate_ctrl: IDLE_CYC must be at least 1");
    end
    if (NCH < 1 || NCH > CG_MAX_NCH) begin : g_bad_nch
        $error("clk_gate_ctrl: NCH out of range 1..32");
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        cg_state_e        state_q;
        cg_state_e        state_d;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic             idle;
        logic             en_r;
        logic             ready_r;
        logic             gated_r;
        logic             lat_en;

        assign idle = !act[i] && !force_on[i];

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            case (state_q)
                CG_RUN: begin
                    if (!idle) begin
                        cnt_d = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = CG_GATED;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                CG_GATED: begin
                    cnt_d = '0;
                    if (!idle) begin
                        state_d = CG_WAKE;
                    end
                end
                CG_WAKE: begin
                    // Inputs are ignored here: the latch needs one low phase to reopen.
                    state_d = CG_RUN;
                    cnt_d   = '0;
                end
                default: begin
                    state_d = CG_RUN;
                    cnt_d   = '0;
                end
            endcase
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                state_q <= CG_RUN;
                cnt_q   <= '0;
                en_r    <= 1'b1;
                ready_r <= 1'b1;
                gated_r <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                en_r    <= (state_d != CG_GATED);
                ready_r <= (state_d == CG_RUN);
                gated_r <= (state_d == CG_GATED);
            end
        end

`ifdef CGC_SCAN_BYPASS_EN
        assign lat_en = en_r | test_en;
`else
        assign lat_en = en_r;
`endif

        cg_cell u_cell (
            .clk  (clk),
            .en   (lat_en),
            .gclk (gclk[i])
        );

        assign en_q[i]  = en_r;
        assign ready[i] = ready_r;
        assign gated[i] = gated_r;
    end
endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Directed bench for clk_gate_ctrl (NCH=8, IDLE_CYC=4): per-cycle vector table plus corner sequences.
module tb_clk_gate_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] act;
    logic [7:0] force_on;
    logic [7:0] gclk;
    logic [7:0] en_q;
    logic [7:0] ready;
    logic [7:0] gated;
`ifdef CGC_SCAN_BYPASS_EN
    logic       test_en = 1'b0;
`endif

    logic [7:0] d;
    logic [7:0] ffq;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    clk_gate_ctrl #(.NCH(8), .IDLE_CYC(4)) dut (
        .clk      (clk),
        .rst      (rst),
`ifdef CGC_SCAN_BYPASS_EN
        .test_en  (test_en),
`endif
        .act      (act),
        .force_on (force_on),
        .gclk     (gclk),
        .en_q     (en_q),
        .ready    (ready),
        .gated    (gated)
    );

    // Downstream flop on a gated clock, used to check d->q ordering on wake.
    always_ff @(posedge gclk[0]) ffq <= d;

    typedef struct {
        logic       rst;
        logic [7:0] act;
        logic [7:0] frc;
        logic [7:0] ready;
        logic [7:0] gated;
        logic [7:0] en;
        logic [7:0] gclk;
        logic       chk_gclk;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ch0 gates at the 4th idle edge and wakes; ch2 counter restarts, gates, force-wakes; ch3 forced on.
        tbl[0]  = '{1'b1, 8'h00, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'hFF, 1'b0};
        tbl[1]  = '{1'b1, 8'h00, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'hFF, 1'b1};
        tbl[2]  = '{1'b0, 8'hF2, 8'h08, 8'hFF, 8'h00, 8'hFF, 8'hFF, 1'b1};
        tbl[3]  = '{1'b0, 8'hF2, 8'h08, 8'hFF, 8'h00, 8'hFF, 8'hFF, 1'b1};
        tbl[4]  = '{1'b0, 8'hF2, 8'h08, 8'hFF, 8'h00, 8'hFF, 8'hFF, 1'b1};
        tbl[5]  = '{1'b0, 8'hF6, 8'h08, 8'hFE, 8'h01, 8'hFE, 8'hFF, 1'b1};
        tbl[6]  = '{1'b0, 8'hF2, 8'h08, 8'hFE, 8'h01, 8'hFE, 8'hFE, 1'b1};
        tbl[7]  = '{1'b0, 8'hF3, 8'h08, 8'hFE, 8'h00, 8'hFF, 8'hFE, 1'b1};
        tbl[8]  = '{1'b0, 8'hF3, 8'h08, 8'hFF, 8'h00, 8'hFF, 8'hFF, 1'b1};
        tbl[9]  = '{1'b0, 8'hF3, 8'h08, 8'hFB, 8'h04, 8'hFB, 8'hFF, 1'b1};
        tbl[10] = '{1'b0, 8'hF3, 8'h08, 8'hFB, 8'h04, 8'hFB, 8'hFB, 1'b1};
        tbl[11] = '{1'b0, 8'hF3, 8'h0C, 8'hFB, 8'h00, 8'hFF, 8'hFB, 1'b1};
        tbl[12] = '{1'b0, 8'hF3, 8'h08, 8'hFF, 8'h00, 8'hFF, 8'hFF, 1'b1};
        tbl[13] = '{1'b0, 8'hF3, 8'h08, 8'hFF, 8'h00, 8'hFF, 8'hFF, 1'b1};

        d = 8'h00;
        for (int i = 0; i < 14; i++) begin
            rst      = tbl[i].rst;
            act      = tbl[i].act;
            force_on = tbl[i].frc;
            tick();
            chk($sformatf("v%0d_ready", i), ready, tbl[i].ready);
            chk($sformatf("v%0d_gated", i), gated, tbl[i].gated);
            chk($sformatf("v%0d_en_q", i), en_q, tbl[i].en);
            if (tbl[i].chk_gclk) chk($sformatf("v%0d_gclk", i), gclk, tbl[i].gclk);
        end

        // force_on[3] with act[3]=0 holds the channel in RUN indefinitely.
        act      = 8'hF7;
        force_on = 8'h08;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk($sformatf("force_hold%0d_gated", i), gated, 8'h00);
        end
        force_on = 8'h00;
        for (int i = 0; i < 4; i++) tick();
        chk("ch3_gated", gated, 8'h08);
        tick();
        chk("ch3_gclk_off", gclk, 8'hF7);
        force_on = 8'h08;
        tick();
        chk("ch3_force_wake_ready", ready, 8'hF7);
        chk("ch3_force_wake_gated", gated, 8'h00);
        tick();
        chk("ch3_force_run_ready", ready, 8'hFF);
        chk("ch3_force_run_gclk", gclk, 8'hFF);

        // Gated-clock flop must capture only pre-edge d values.
        force_on = 8'h00;
        act = 8'hFE;
        d = 8'h11; tick();
        d = 8'h22; tick();
        d = 8'h33; tick();
        d = 8'h44; tick();
        chk("ffq_gate_edge_gated", gated, 8'h01);
        chk("ffq_gate_edge", ffq, 8'h44);
        d = 8'h55; tick();
        chk("ffq_suppressed", ffq, 8'h44);
        act = 8'hFF;
        d = 8'h66; tick();
        chk("ffq_wake_edge", ffq, 8'h44);
        chk("ffq_wake_ready", ready, 8'hFE);
        d = 8'h3C; tick();
        chk("ffq_run_edge", ffq, 8'h3C);
        chk("ffq_run_ready", ready, 8'hFF);

        // Reset while ch1 is in WAKE and ch4 in GATED.
        act = 8'hED;
        for (int i = 0; i < 4; i++) tick();
        chk("pre_rst_gated", gated, 8'h12);
        act = 8'hEF;
        tick();
        chk("pre_rst_ready", ready, 8'hED);
        chk("pre_rst_gated2", gated, 8'h10);
        rst = 1'b1;
        tick();
        chk("mid_rst_ready", ready, 8'hFF);
        chk("mid_rst_gated", gated, 8'h00);
        chk("mid_rst_en_q", en_q, 8'hFF);
        chk("mid_rst_gclk", gclk, 8'hEF);
        rst = 1'b0;
        act = 8'hFF;
        tick();
        chk("post_rst_gclk", gclk, 8'hFF);

`ifdef CGC_SCAN_BYPASS_EN
        act = 8'hFE;
        for (int i = 0; i < 5; i++) tick();
        chk("scan_pre_gclk", gclk, 8'hFE);
        test_en = 1'b1;
        tick();
        chk("scan_gated", gated, 8'h01);
        chk("scan_gclk", gclk, 8'hFF);
        test_en = 1'b0;
        act = 8'hFF;
        tick();
        tick();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
